// File: rtl/btn_key_sched.sv
// Push-button front end: 1 ms sample tick, per-button debounce and
// press/hold/auto-repeat FSMs, and a lowest-index-first key event arbiter.
module btn_key_sched #(
  parameter int N_BTN      = 4,
  parameter int TICK_DIV   = 50000,
  parameter int DB_LEN     = 8,
  parameter int HOLD_TICKS = 500,
  parameter int RPT_TICKS  = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_in,
  output logic             tick_1ms,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic             key_valid,
  output logic [2:0]       key_code
);

  localparam int TW      = $clog2(TICK_DIV);
  localparam int HOLD_MX = (HOLD_TICKS > RPT_TICKS) ? HOLD_TICKS : RPT_TICKS;
  localparam int CW      = $clog2(HOLD_MX + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_TICKS - 1);
  localparam logic [CW-1:0] RPT_LAST  = CW'(RPT_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RPT  = 2'd2
  } state_t;

  // Shared sample tick
  logic [TW-1:0] tcnt_q, tcnt_d;

  always_comb begin
    tcnt_d = (tcnt_q == TICK_LAST) ? '0 : tcnt_q + TW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tcnt_q <= '0;
    else        tcnt_q <= tcnt_d;
  end

  assign tick_1ms = (tcnt_q == TICK_LAST);

  // Two-flop synchroniser for the raw inputs
  logic [N_BTN-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_btn
      logic [DB_LEN-1:0] sh_q, sh_d;
      logic              lvl_q, lvl_d;
      state_t            st_q, st_d;
      logic [CW-1:0]     cnt_q, cnt_d;
      logic              prs_q, prs_d;
      logic              rel_q, rel_d;

      // Edge decisions use lvl_d so press/release pulse with the level change.
      always_comb begin
        sh_d  = sh_q;
        lvl_d = lvl_q;
        if (tick_1ms) begin
          sh_d = {sh_q[DB_LEN-2:0], sync2_q[gi]};
          if (&sh_d)       lvl_d = 1'b1;
          else if (~|sh_d) lvl_d = 1'b0;
        end

        st_d  = st_q;
        cnt_d = cnt_q;
        prs_d = 1'b0;
        rel_d = 1'b0;
        case (st_q)
          IDLE: begin
            if (lvl_d && !lvl_q) begin
              prs_d = 1'b1;
              cnt_d = '0;
              st_d  = HOLD;
            end
          end
          HOLD: begin
            if (!lvl_d) begin
              rel_d = 1'b1;
              cnt_d = '0;
              st_d  = IDLE;
            end else if (tick_1ms) begin
              if (cnt_q == HOLD_LAST) begin
                prs_d = 1'b1;
                cnt_d = '0;
                st_d  = RPT;
              end else begin
                cnt_d = cnt_q + CW'(1);
              end
            end
          end
          RPT: begin
            if (!lvl_d) begin
              rel_d = 1'b1;
              cnt_d = '0;
              st_d  = IDLE;
            end else if (tick_1ms) begin
              if (cnt_q == RPT_LAST) begin
                prs_d = 1'b1;
                cnt_d = '0;
              end else begin
                cnt_d = cnt_q + CW'(1);
              end
            end
          end
          default: begin
            st_d  = IDLE;
            cnt_d = '0;
          end
        endcase
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sh_q  <= '0;
          lvl_q <= 1'b0;
          st_q  <= IDLE;
          cnt_q <= '0;
          prs_q <= 1'b0;
          rel_q <= 1'b0;
        end else begin
          sh_q  <= sh_d;
          lvl_q <= lvl_d;
          st_q  <= st_d;
          cnt_q <= cnt_d;
          prs_q <= prs_d;
          rel_q <= rel_d;
        end
      end

      assign btn_level[gi]   = lvl_q;
      assign btn_press[gi]   = prs_q;
      assign btn_release[gi] = rel_q;
    end
  endgenerate

  // Arbiter: a press landing on the bit being served re-arms it.
  logic [N_BTN-1:0] pend_q, pend_d, grant;
  logic             kv_q, kv_d;
  logic [2:0]       kc_q, kc_d;

  always_comb begin
    grant = '0;
    kc_d  = kc_q;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        kc_d     = 3'(i);
      end
    end
    kv_d   = |pend_q;
    pend_d = (pend_q & ~grant) | btn_press;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      kv_q   <= 1'b0;
      kc_q   <= '0;
    end else begin
      pend_q <= pend_d;
      kv_q   <= kv_d;
      kc_q   <= kc_d;
    end
  end

  assign key_valid = kv_q;
  assign key_code  = kc_q;

endmodule

// File: tb/tb_btn_key_sched.sv
// Directed bench for btn_key_sched with short tick/debounce/repeat periods.
module tb_btn_key_sched;
  localparam int NB = 4;
  localparam int TD = 4;
  localparam int DB = 4;
  localparam int HT = 3;
  localparam int RT = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NB-1:0] btn_in = '0;
  logic          tick_1ms;
  logic [NB-1:0] btn_level, btn_press, btn_release;
  logic          key_valid;
  logic [2:0]    key_code;

  btn_key_sched #(
    .N_BTN(NB), .TICK_DIV(TD), .DB_LEN(DB), .HOLD_TICKS(HT), .RPT_TICKS(RT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .tick_1ms(tick_1ms),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .key_valid(key_valid), .key_code(key_code)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int press_cnt[NB];
  int rel_cnt[NB];
  int kv_cnt[8];
  int kv_total;

  typedef struct {
    logic          rst;
    logic [NB-1:0] btn;
    logic          tick;
    logic [NB-1:0] lvl;
    logic [NB-1:0] prs;
    logic [NB-1:0] rel;
    logic          kv;
    logic [2:0]    kc;
  } vec_t;

  vec_t vt[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < NB; i++) begin
      press_cnt[i] = 0;
      rel_cnt[i]   = 0;
    end
    for (int i = 0; i < 8; i++) kv_cnt[i] = 0;
    kv_total = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NB; i++) begin
      press_cnt[i] += int'(btn_press[i]);
      rel_cnt[i]   += int'(btn_release[i]);
    end
    if (key_valid === 1'b1) begin
      kv_cnt[key_code]++;
      kv_total++;
      $display("key t=%0t code=%0d", $time, key_code);
    end
  endtask

  task automatic wait_tick(input string name);
    int n = 0;
    while (tick_1ms !== 1'b1 && n < 2 * TD) begin
      step();
      n++;
    end
    check(name, tick_1ms, 1);
  endtask

  task automatic next_tick(input string name);
    step();
    wait_tick(name);
  endtask

  task automatic wait_level(input int idx, input logic val, input string name);
    int n = 0;
    while (btn_level[idx] !== val && n < 40) begin
      step();
      n++;
    end
    check(name, btn_level[idx], val);
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    btn_in = '0;
    repeat (3) step();
    rst_n = 1'b1;
    clear_counts();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tc;
    int rel_tc;
    int n;
    int ptimes[$];
    logic lvl_seen;

    clear_counts();

    // Test 1: reset and power-up with all buttons held, cycle-accurate table
    for (int r = 0; r < 10; r++)
      vt.push_back('{rst: 1'b0, btn: 4'hF, tick: 1'b0, lvl: 4'h0, prs: 4'h0,
                     rel: 4'h0, kv: 1'b0, kc: 3'd0});
    for (int k = 1; k <= 23; k++)
      vt.push_back('{rst: 1'b1, btn: 4'hF,
                     tick: (k % 4 == 3),
                     lvl: (k >= 16) ? 4'hF : 4'h0,
                     prs: (k == 16) ? 4'hF : 4'h0,
                     rel: 4'h0,
                     kv: (k >= 18 && k <= 21),
                     kc: (k < 18) ? 3'd0 : (k <= 21) ? 3'(k - 18) : 3'd3});
    for (int r = 0; r < vt.size(); r++) begin
      rst_n  = vt[r].rst;
      btn_in = vt[r].btn;
      step();
      check($sformatf("t1 tick row%0d", r), tick_1ms, vt[r].tick);
      check($sformatf("t1 level row%0d", r), btn_level, vt[r].lvl);
      check($sformatf("t1 press row%0d", r), btn_press, vt[r].prs);
      check($sformatf("t1 release row%0d", r), btn_release, vt[r].rel);
      check($sformatf("t1 kvalid row%0d", r), key_valid, vt[r].kv);
      check($sformatf("t1 kcode row%0d", r), key_code, vt[r].kc);
    end

    // Test 2: bounce rejection on button 0
    do_reset();
    wait_tick("t2 align");
    lvl_seen = 1'b0;
    for (int t = 0; t < 20; t++) begin
      btn_in[0] = ~btn_in[0];
      next_tick("t2 toggle tick");
      if (btn_level[0] !== 1'b0) lvl_seen = 1'b1;
    end
    check("t2 level during bounce", lvl_seen, 0);
    btn_in[0] = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      next_tick("t2 stable tick");
      check($sformatf("t2 level before stable tick %0d edge", t), btn_level[0], 0);
    end
    step();
    check("t2 level after 4 stable ticks", btn_level[0], 1);
    check("t2 press at rise", btn_press[0], 1);
    repeat (6) step();
    check("t2 press count", press_cnt[0], 1);
    check("t2 key code0 count", kv_cnt[0], 1);
    check("t2 key total", kv_total, 1);

    // Test 3: auto-repeat on button 2, level falls on the 10th tick after rise
    do_reset();
    wait_tick("t3 align");
    btn_in[2] = 1'b1;
    wait_level(2, 1'b1, "t3 level rise");
    check("t3 press at rise", btn_press[2], 1);
    ptimes.delete();
    ptimes.push_back(0);
    tc = 0;
    n = 0;
    while (btn_release[2] !== 1'b1 && n < 80) begin
      step();
      n++;
      if (btn_press[2] === 1'b1) ptimes.push_back(tc);
      if (tick_1ms === 1'b1) begin
        tc++;
        if (tc == 6) btn_in[2] = 1'b0;
      end
    end
    check("t3 release seen", btn_release[2], 1);
    check("t3 release tick", tc, 10);
    repeat (16) step();
    check("t3 press count", ptimes.size(), 5);
    if (ptimes.size() == 5) begin
      check("t3 press tick 0", ptimes[0], 0);
      check("t3 press tick 1", ptimes[1], 3);
      check("t3 press tick 2", ptimes[2], 5);
      check("t3 press tick 3", ptimes[3], 7);
      check("t3 press tick 4", ptimes[4], 9);
    end
    check("t3 press_cnt", press_cnt[2], 5);
    check("t3 key code2 count", kv_cnt[2], 5);
    check("t3 key total", kv_total, 5);
    check("t3 release count", rel_cnt[2], 1);
    check("t3 level idle", btn_level[2], 0);

    // Test 4: buttons 3 and 1 press together
    do_reset();
    wait_tick("t4 align");
    btn_in = 4'b1010;
    n = 0;
    while (btn_press === 4'b0000 && n < 40) begin
      step();
      n++;
    end
    check("t4 simultaneous press", btn_press, 4'b1010);
    step();
    check("t4 pending cycle kv", key_valid, 0);
    step();
    check("t4 first kv", key_valid, 1);
    check("t4 first code", key_code, 1);
    step();
    check("t4 second kv", key_valid, 1);
    check("t4 second code", key_code, 3);
    step();
    check("t4 idle kv", key_valid, 0);
    check("t4 code holds", key_code, 3);
    check("t4 code1 count", kv_cnt[1], 1);
    check("t4 code3 count", kv_cnt[3], 1);
    check("t4 key total", kv_total, 2);

    // Test 5: level fall on the same tick as the first RPT deadline
    do_reset();
    wait_tick("t5 align");
    btn_in[0] = 1'b1;
    wait_level(0, 1'b1, "t5 level rise");
    tc = 0;
    rel_tc = -1;
    n = 0;
    while (rel_tc < 0 && n < 80) begin
      step();
      n++;
      if (btn_release[0] === 1'b1) begin
        rel_tc = tc;
        check("t5 no press with release", btn_press[0], 0);
      end
      if (tick_1ms === 1'b1) begin
        tc++;
        if (tc == 1) btn_in[0] = 1'b0;
      end
    end
    check("t5 release tick", rel_tc, 5);
    repeat (12) step();
    check("t5 press count", press_cnt[0], 2);
    check("t5 release count", rel_cnt[0], 1);
    check("t5 key total", kv_total, 2);

    // Test 6: asynchronous reset while in RPT with a pending key
    do_reset();
    wait_tick("t6 align");
    btn_in[1] = 1'b1;
    n = 0;
    while (press_cnt[1] < 2 && n < 80) begin
      step();
      n++;
    end
    check("t6 reached repeat", press_cnt[1], 2);
    step();
    #2;
    rst_n  = 1'b0;
    btn_in = '0;
    #1;
    check("t6 async tick", tick_1ms, 0);
    check("t6 async level", btn_level, 0);
    check("t6 async press", btn_press, 0);
    check("t6 async release", btn_release, 0);
    check("t6 async kvalid", key_valid, 0);
    check("t6 async kcode", key_code, 0);
    repeat (3) step();
    rst_n = 1'b1;
    clear_counts();
    repeat (40) step();
    check("t6 no stale key", kv_total, 0);
    check("t6 no release", rel_cnt[1], 0);
    btn_in[1] = 1'b1;
    n = 0;
    while (key_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check("t6 new press key", key_valid, 1);
    check("t6 new press code", key_code, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/btn_key_sched.md
Name: btn_key_sched

Overview:
- Front-end controller for all push-buttons on the board.
- Generates the shared 1 ms sampling tick from the system clock and debounces N buttons with 8-sample all-equal filtering.
- Per-button state machine adds press/release events and hold-to-auto-repeat.
- A lowest-index-first arbiter serialises press events into a single key_valid/key_code stream for the ALU operand/opcode entry logic.

Parameters:
- N_BTN, 4, number of buttons (1..8).
- TICK_DIV, 50000, clk cycles per sample tick (50 MHz -> 1 ms); minimum 2.
- DB_LEN, 8, consecutive equal samples required to change a debounced level.
- HOLD_TICKS, 500, ticks a button stays held after its press before the first auto-repeat.
- RPT_TICKS, 100, ticks between later auto-repeats.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- btn_in  in  N_BTN  raw asynchronous button inputs, active high.
- tick_1ms  out  1  one-clk pulse every TICK_DIV cycles.
- btn_level  out  N_BTN  debounced levels.
- btn_press  out  N_BTN  one-clk pulse per press event, initial or repeat.
- btn_release  out  N_BTN  one-clk pulse when the debounced level falls.
- key_valid  out  1  one-clk pulse: key_code is valid.
- key_code  out  3  index of the button served.

Behaviour:
- Reset (async, rst_n=0):
  - Tick counter, synchronisers, shift registers, repeat counters and pending bits clear to 0.
  - All FSMs go to IDLE.
  - All outputs are 0.
  - On deassertion, operation restarts from the reset state. An asserted reset mid-hold drops the hold with no release pulse.
- Synchroniser: each btn_in passes through a 2-FF synchroniser on clk before any sampling.
- Tick:
  - Counter runs 0..TICK_DIV-1 and wraps.
  - tick_1ms=1 in exactly the cycle the counter equals TICK_DIV-1.
  - First tick comes TICK_DIV cycles after reset release.
- Debounce (per button, only on cycles with tick_1ms=1):
  - The DB_LEN-bit shift register shifts left and takes in the synchronised bit at bit 0.
  - If the shifted value is all ones, the level register goes to 1. If all zeros, it goes to 0. Otherwise the level holds.
  - btn_level changes in the cycle after the deciding tick.
- Per-button FSM (IDLE, HOLD, RPT), with a tick counter per button:
  - IDLE: when btn_level rises, btn_press=1 for that first cycle, counter clears, go to HOLD.
  - HOLD: counter increments on each tick. When counter reaches HOLD_TICKS: btn_press=1 for one cycle, counter clears, go to RPT.
  - RPT: counter increments on each tick. When it reaches RPT_TICKS: btn_press=1, counter clears, stay in RPT.
  - HOLD or RPT: a level fall has priority over a repeat in the same cycle. btn_release=1 in the cycle btn_level first reads 0, no press, go to IDLE.
- Arbiter:
  - Each btn_press sets pending[i].
  - Every cycle with any pending bit set, the lowest set index is served. key_valid=1 and key_code=index in the next cycle, and that pending bit clears.
  - One key is served per cycle.
  - A press arriving in the same cycle its pending bit is being served re-sets the bit, so the event is not lost.
  - A second press on a pending bit that is not being served merges with it and is counted once.
  - With no pending bits: key_valid=0 and key_code holds its last value.
- key_code is zero-extended when N_BTN<8.

Test Plan:
1. Reset:
   - Stimulus: TICK_DIV=4, DB_LEN=4. Hold rst_n=0 for 10 cycles with btn_in=4'hF, then release.
   - Required: all outputs 0 during reset. First tick_1ms at cycle 4 after release. btn_level=4'hF after the 4th tick. btn_press=4'hF pulses once. key_code is then served as 0,1,2,3 on 4 consecutive cycles.
2. Bounce rejection:
   - Stimulus: btn_in[0] toggles every tick for 20 ticks, then stays 1.
   - Required: btn_level[0] stays 0 through the toggling and rises only after 4 stable ticks. Exactly one btn_press[0] and one key_valid with key_code=0.
3. Auto-repeat:
   - Stimulus: HOLD_TICKS=3, RPT_TICKS=2. Hold btn 2 for 10 ticks after its level rises, then release.
   - Required: presses at 0, 3, 5, 7, 9 ticks after the rise (5 key_valid with key_code=2). One btn_release[2]. FSM back in IDLE.
4. Simultaneous arbitration:
   - Stimulus: buttons 3 and 1 have btn_press in the same cycle.
   - Required: key_code=1, then key_code=3 on consecutive cycles. Each appears once.
5. Release beats repeat:
   - Stimulus: the level fall coincides with a repeat deadline.
   - Required: btn_release pulses, no btn_press, no key_valid.
6. Async reset mid-RPT:
   - Stimulus: assert rst_n=0 while a button is in RPT with a pending bit set.
   - Required: outputs drop to 0 immediately with no clock edge. No key_valid after release until a new debounced press.
